multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, meaning the maximum number of MEM-state cycles without dReady before a timeout trap.
REQ-002 SHALL have parameter BRANCH_EXT, default 1, meaning BNE/BLT/BGE are legal when 1; only BEQ is legal when 0.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of the retired-instruction counter.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port instr, input, 32 bits: instruction word from instruction memory, valid during IF.
REQ-008 Port Zero, input, 1 bit: ALU result equals zero.
REQ-009 Port Lt, input, 1 bit: ALU signed less-than flag.
REQ-010 Port dReady, input, 1 bit: data-memory access-complete acknowledge.
REQ-011 Outputs ALUSrc (1 bit), ALUCtrl (4 bits), RegWrite, MemToReg, loadPC, PCSrc, MemRead and MemWrite (1 bit each): datapath and memory controls.
REQ-012 Outputs state (3 bits), trap (1 bit), trap_cause (2 bits), retired (1-bit pulse) and retire_count (CNT_W bits): status.

Function
REQ-013 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4 and TRAP=5, and drive the current state on port state.
REQ-014 SHALL latch instr into an internal IR on the IF->ID edge; all later decoding SHALL use IR only.
REQ-015 Transitions:
- IF->ID, then ID->EX, unconditionally.
- EX->MEM for LW/SW; EX->WB otherwise.
- MEM->WB on the cycle dReady=1.
- WB->IF.
REQ-016 In ID, an illegal opcode or funct field SHALL move to TRAP with trap_cause=01.
- Legal opcodes: LW, SW, OP-IMM, OP, BRANCH.
REQ-017 In MEM, if dReady stays 0 for MEM_WAIT_MAX consecutive cycles, the FSM SHALL move to TRAP with trap_cause=10 and deassert MemRead/MemWrite.
REQ-018 The wait counter SHALL clear on entry to MEM; dReady on the MEM_WAIT_MAX-th cycle itself SHALL win over the timeout.
REQ-019 TRAP SHALL be sticky until rst; while in TRAP: trap=1, and all write/load controls (RegWrite, MemWrite, MemRead, loadPC) SHALL be 0.
REQ-020 MemRead (LW) or MemWrite (SW) SHALL be 1 for every cycle in MEM and 0 in all other states.
REQ-021 In WB, for exactly one cycle:
- loadPC=1 and retired=1;
- retire_count increments, wrapping modulo 2^CNT_W.
REQ-022 In WB, RegWrite=1 for LW, OP and OP-IMM; MemToReg=1 only for LW; RegWrite and MemToReg SHALL be 0 in all other states.
REQ-023 In WB, PCSrc=1 only for a taken branch:
- BEQ: Zero
- BNE: !Zero
- BLT: Lt
- BGE: !Lt
REQ-024 ALUSrc SHALL be 1 for LW, SW and OP-IMM; 0 otherwise.
REQ-025 ALUCtrl encoding: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101.
REQ-026 ALUCtrl by instruction:
- LW/SW: ADD.
- Branches: SUB.
- OP-IMM: decoded from funct3; funct3=101 uses instr[30] (0 SRLI, 1 SRAI).
- OP: decoded from funct7/funct3; SUB requires funct7=0100000 with funct3=000, SRA requires funct7=0100000 with funct3=101.
REQ-027 All decode outputs SHALL be combinational from state and IR, with no latches inferred.
- Undefined combinations SHALL drive ALUCtrl=0000, ALUSrc=0.

Reset
REQ-028 On rst=1 at a clock edge:
- state=IF, IR=0, wait counter=0, retire_count=0, trap=0, trap_cause=00.
- While in IF after reset, all control outputs SHALL be 0.
REQ-029 Reset asserted mid-MEM SHALL abort the access, with MemRead/MemWrite low from the next cycle.

Verification
REQ-030 ADD x3,x1,x2 (0x002081B3) -> states 0,1,2,4,0; ALUCtrl=0010, ALUSrc=0; RegWrite=1 and loadPC=1 in WB only; retire_count=1.
REQ-031 LW with dReady raised on the 3rd MEM cycle -> MemRead=1 for 3 cycles; then WB with MemToReg=1, RegWrite=1; 7 cycles total.
REQ-032 BNE with Zero=0 -> PCSrc=1 in WB; same instruction with Zero=1 -> PCSrc=0; with BRANCH_EXT=0, BNE -> TRAP, trap_cause=01.
REQ-033 SW with dReady held 0 and MEM_WAIT_MAX=4 -> TRAP after 4 MEM cycles, trap_cause=10, MemWrite=0; stays in TRAP until rst.
REQ-034 SRA (funct7=0100000, funct3=101, OP) -> ALUCtrl=1010; SRAI -> ALUCtrl=1010 with ALUSrc=1.
REQ-035 rst pulsed during MEM of LW -> next cycle state=IF, MemRead=0, retire_count=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM: IF/ID/EX/MEM/WB with sticky trap.
// Decodes a latched IR and drives datapath, memory and retirement status.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int BRANCH_EXT   = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             Zero,
    input  logic             Lt,
    input  logic             dReady,
    output logic             ALUSrc,
    output logic [3:0]       ALUCtrl,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             loadPC,
    output logic             PCSrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             retired,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    state_t           cur;
    state_t           nxt;
    logic [31:0]      ir;
    logic [WW-1:0]    wcnt;
    logic [1:0]       cause;
    logic [CNT_W-1:0] rcnt;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ir_unused;

    assign opc       = ir[6:0];
    assign f3        = ir[14:12];
    assign f7        = ir[31:25];
    assign ir_unused = ^{ir[24:15], ir[11:7]};

    logic       ok;
    logic [3:0] alu_d;
    logic       k_ld, k_st, k_imm, k_op, k_br;
    logic       taken;

    // SLTU/SLTIU have no ALU code here, so they decode as illegal
    always_comb begin
        ok    = 1'b0;
        alu_d = ALU_AND;
        k_ld  = 1'b0;
        k_st  = 1'b0;
        k_imm = 1'b0;
        k_op  = 1'b0;
        k_br  = 1'b0;
        unique case (opc)
            OPC_LD: begin
                k_ld  = 1'b1;
                ok    = (f3 == 3'b010);
                alu_d = ALU_ADD;
            end
            OPC_ST: begin
                k_st  = 1'b1;
                ok    = (f3 == 3'b010);
                alu_d = ALU_ADD;
            end
            OPC_IMM: begin
                k_imm = 1'b1;
                ok    = 1'b1;
                unique case (f3)
                    3'b000: alu_d = ALU_ADD;
                    3'b010: alu_d = ALU_SLT;
                    3'b100: alu_d = ALU_XOR;
                    3'b110: alu_d = ALU_OR;
                    3'b111: alu_d = ALU_AND;
                    3'b001: begin
                        alu_d = ALU_SLL;
                        ok    = (f7 == F7_BASE);
                    end
                    3'b101: begin
                        alu_d = ir[30] ? ALU_SRA : ALU_SRL;
                        ok    = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                    default: ok = 1'b0;
                endcase
            end
            OPC_OP: begin
                k_op = 1'b1;
                if (f7 == F7_BASE) begin
                    ok = 1'b1;
                    unique case (f3)
                        3'b000: alu_d = ALU_ADD;
                        3'b001: alu_d = ALU_SLL;
                        3'b010: alu_d = ALU_SLT;
                        3'b100: alu_d = ALU_XOR;
                        3'b101: alu_d = ALU_SRL;
                        3'b110: alu_d = ALU_OR;
                        3'b111: alu_d = ALU_AND;
                        default: ok = 1'b0;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'b000) begin
                        ok    = 1'b1;
                        alu_d = ALU_SUB;
                    end else if (f3 == 3'b101) begin
                        ok    = 1'b1;
                        alu_d = ALU_SRA;
                    end
                end
            end
            OPC_BR: begin
                k_br  = 1'b1;
                alu_d = ALU_SUB;
                ok    = (f3 == 3'b000) ||
                        ((BRANCH_EXT != 0) &&
                         ((f3 == 3'b001) || (f3 == 3'b100) ||
                          (f3 == 3'b101)));
            end
            default: ok = 1'b0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        unique case (f3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = Lt;
            3'b101:  taken = !Lt;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur   <= S_IF;
            ir    <= '0;
            wcnt  <= '0;
            cause <= 2'b00;
            rcnt  <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_IF)
                ir <= instr;
            wcnt <= (cur == S_MEM) ? wcnt + 1'b1 : '0;
            if (cur == S_WB)
                rcnt <= rcnt + 1'b1;
            if (nxt == S_TRAP && cur != S_TRAP)
                cause <= (cur == S_ID) ? 2'b01 : 2'b10;
        end
    end

    // dReady is checked before the timeout so a late ack still completes
    always_comb begin
        nxt = cur;
        unique case (cur)
            S_IF:  nxt = S_ID;
            S_ID:  nxt = ok ? S_EX : S_TRAP;
            S_EX:  nxt = (k_ld || k_st) ? S_MEM : S_WB;
            S_MEM: begin
                if (dReady)
                    nxt = S_WB;
                else if (wcnt == WW'(MEM_WAIT_MAX - 1))
                    nxt = S_TRAP;
            end
            S_WB:   nxt = S_IF;
            S_TRAP: nxt = S_TRAP;
            default: nxt = S_IF;
        endcase
    end

    always_comb begin
        ALUSrc   = 1'b0;
        ALUCtrl  = ALU_AND;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        loadPC   = 1'b0;
        PCSrc    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        trap     = 1'b0;
        retired  = 1'b0;
        if (ok && cur inside {S_ID, S_EX, S_MEM, S_WB}) begin
            ALUCtrl = alu_d;
            ALUSrc  = k_ld || k_st || k_imm;
        end
        unique case (cur)
            S_MEM: begin
                MemRead  = ok && k_ld;
                MemWrite = ok && k_st;
            end
            S_WB: begin
                RegWrite = ok && (k_ld || k_imm || k_op);
                MemToReg = ok && k_ld;
                PCSrc    = ok && k_br && taken;
                loadPC   = 1'b1;
                retired  = 1'b1;
            end
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    assign state        = cur;
    assign trap_cause   = cause;
    assign retire_count = rcnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized and directed bench for multicycle_ctrl.
// Expected traces are built from instruction-level rules, not FSM code.
module tb_multicycle_ctrl;

    localparam logic [3:0] A_AND  = 4'b0000;
    localparam logic [3:0] A_OR   = 4'b0001;
    localparam logic [3:0] A_ADD  = 4'b0010;
    localparam logic [3:0] A_SUB  = 4'b0110;
    localparam logic [3:0] A_SLT  = 4'b0111;
    localparam logic [3:0] A_SRL  = 4'b1000;
    localparam logic [3:0] A_SLL  = 4'b1001;
    localparam logic [3:0] A_SRA  = 4'b1010;
    localparam logic [3:0] A_XOR  = 4'b1101;
    localparam logic [3:0] A_NONE = 4'b1111;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_SRA  = 32'h4020D1B3;
    localparam logic [31:0] I_SRAI = 32'h4030D193;

    localparam int WAIT_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero, Lt, dReady;

    logic       alu_src, reg_write, mem_to_reg, load_pc, pc_src;
    logic       mem_read, mem_write, trap, retired;
    logic [3:0] alu_ctrl;
    logic [2:0] st;
    logic [1:0] cause;
    logic [3:0] rcnt;

    logic        nb_alu_src, nb_reg_write, nb_mem_to_reg, nb_load_pc;
    logic        nb_pc_src, nb_mem_read, nb_mem_write, nb_trap, nb_retired;
    logic [3:0]  nb_alu_ctrl;
    logic [2:0]  nb_st;
    logic [1:0]  nb_cause;
    logic [31:0] nb_rcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .MEM_WAIT_MAX(WAIT_MAX), .BRANCH_EXT(1), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .Lt(Lt),
        .dReady(dReady), .ALUSrc(alu_src), .ALUCtrl(alu_ctrl),
        .RegWrite(reg_write), .MemToReg(mem_to_reg), .loadPC(load_pc),
        .PCSrc(pc_src), .MemRead(mem_read), .MemWrite(mem_write),
        .state(st), .trap(trap), .trap_cause(cause), .retired(retired),
        .retire_count(rcnt)
    );

    multicycle_ctrl #(.BRANCH_EXT(0)) dut_nb (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .Lt(Lt),
        .dReady(dReady), .ALUSrc(nb_alu_src), .ALUCtrl(nb_alu_ctrl),
        .RegWrite(nb_reg_write), .MemToReg(nb_mem_to_reg),
        .loadPC(nb_load_pc), .PCSrc(nb_pc_src), .MemRead(nb_mem_read),
        .MemWrite(nb_mem_write), .state(nb_st), .trap(nb_trap),
        .trap_cause(nb_cause), .retired(nb_retired),
        .retire_count(nb_rcnt)
    );

    // cls: 0 LW, 1 SW, 2 OP-IMM, 3 OP, 4 BRANCH, -1 unknown opcode
    function automatic void ref_dec(input logic [31:0] ins,
                                    output bit ok, output int cls,
                                    output logic [3:0] alu);
        logic [3:0] tbl [8];
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        tbl = '{A_ADD, A_SLL, A_SLT, A_NONE, A_XOR, A_SRL, A_OR, A_AND};
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        ok  = 0;
        cls = -1;
        alu = A_NONE;
        if (opc == 7'h03) begin
            cls = 0; alu = A_ADD; ok = (f3 == 3'd2);
        end else if (opc == 7'h23) begin
            cls = 1; alu = A_ADD; ok = (f3 == 3'd2);
        end else if (opc == 7'h13) begin
            cls = 2;
            alu = tbl[f3];
            if (f3 == 3'd1 && f7 != 7'h00) alu = A_NONE;
            if (f3 == 3'd5 && f7 == 7'h20) alu = A_SRA;
            else if (f3 == 3'd5 && f7 != 7'h00) alu = A_NONE;
            ok = (alu != A_NONE);
        end else if (opc == 7'h33) begin
            cls = 3;
            if (f7 == 7'h00) alu = tbl[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) alu = A_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) alu = A_SRA;
            ok = (alu != A_NONE);
        end else if (opc == 7'h63) begin
            cls = 4; alu = A_SUB;
            ok = f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
        end
        if (!ok) alu = A_AND;
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3,
                                     input logic z, input logic l);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; instr = '0; dReady = 0; Zero = 0; Lt = 0;
        step();
        rst = 1'b0;
    endtask

    task automatic exec_simple(input logic [31:0] ins);
        instr = ins; dReady = 0;
        step();
        instr = $urandom;
        repeat (3) step();
    endtask

    task automatic test_reset();
        logic [10:0] ctl;
        rst = 1'b1; instr = $urandom; dReady = 1; Zero = 1; Lt = 1;
        step(); step();
        rst = 1'b0; #1;
        ctl = {alu_src, alu_ctrl, reg_write, mem_to_reg, load_pc,
               pc_src, mem_read, mem_write};
        checks++;
        if (st !== 3'd0) begin
            errors++; $display("FAIL reset_state got %0d want 0", st);
        end
        checks++;
        if ({trap, cause, rcnt} !== 7'd0) begin
            errors++;
            $display("FAIL reset_status trap=%b cause=%b cnt=%0d want 0",
                     trap, cause, rcnt);
        end
        checks++;
        if ({ctl, retired} !== 12'd0) begin
            errors++; $display("FAIL reset_ctl got %h want 0", {ctl, retired});
        end
    endtask

    task automatic test_add();
        int exp_st [4];
        exp_st = '{0, 1, 2, 4};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            instr = (k == 0) ? I_ADD : $urandom;
            Zero = 1'($urandom);
            #1;
            checks++;
            if (st !== 3'(exp_st[k])) begin
                errors++;
                $display("FAIL add_state k=%0d got %0d want %0d", k, st, exp_st[k]);
            end
            if (k == 2) begin
                checks++;
                if ({alu_src, alu_ctrl} !== {1'b0, A_ADD}) begin
                    errors++;
                    $display("FAIL add_alu got %b/%b want 0/0010",
                             alu_src, alu_ctrl);
                end
            end
            checks++;
            if ({reg_write, load_pc} !== ((k == 3) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL add_wb k=%0d got rw=%b lpc=%b", k, reg_write, load_pc);
            end
            step();
        end
        checks++;
        if ({st, rcnt} !== {3'd0, 4'd1}) begin
            errors++;
            $display("FAIL add_retire state=%0d cnt=%0d want 0/1", st, rcnt);
        end
    endtask

    task automatic test_lw_wait();
        int n, mr, m;
        bit done, wb_ok;
        do_reset();
        n = 0; mr = 0; m = 0; done = 0; wb_ok = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            instr = (k == 0) ? I_LW : $urandom;
            if (st == 3'd3) m++;
            dReady = (st == 3'd3 && m == 3);
            #1;
            n++;
            if (mem_read) mr++;
            if (st == 3'd4 && mem_to_reg && reg_write) wb_ok = 1;
            step();
            if (st == 3'd0) done = 1;
        end
        checks++;
        if (!done || n != 7) begin
            errors++; $display("FAIL lw_cycles got %0d done=%b want 7", n, done);
        end
        checks++;
        if (mr != 3) begin
            errors++; $display("FAIL lw_memread got %0d want 3", mr);
        end
        checks++;
        if (!wb_ok) begin
            errors++; $display("FAIL lw_wb got 0 want MemToReg=RegWrite=1");
        end
    endtask

    task automatic test_branch(input logic z);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            instr = (k == 0) ? I_BNE : $urandom;
            Zero = z; Lt = 1'($urandom);
            #1;
            if (k == 2) begin
                checks++;
                if ({nb_st, nb_trap, nb_cause} !== {3'd5, 1'b1, 2'b01}) begin
                    errors++;
                    $display("FAIL bne_noext got st=%0d trap=%b cause=%b want 5/1/01",
                             nb_st, nb_trap, nb_cause);
                end
            end
            if (k == 3) begin
                checks++;
                if ({st, pc_src} !== {3'd4, !z}) begin
                    errors++;
                    $display("FAIL bne_pcsrc z=%b got st=%0d pcsrc=%b want 4/%b",
                             z, st, pc_src, !z);
                end
            end
            step();
        end
    endtask

    task automatic test_sw_timeout();
        int exp_st;
        int ok_st [8];
        ok_st = '{0, 1, 2, 3, 3, 3, 3, 4};
        do_reset();
        for (int k = 0; k < 12; k++) begin
            instr = (k == 0) ? I_SW : $urandom;
            dReady = (k >= 7) ? 1'($urandom) : 1'b0;
            #1;
            exp_st = (k < 3) ? k : ((k < 7) ? 3 : 5);
            checks++;
            if (st !== 3'(exp_st)) begin
                errors++;
                $display("FAIL sw_to_state k=%0d got %0d want %0d", k, st, exp_st);
            end
            if (k >= 3 && k < 7) begin
                checks++;
                if (mem_write !== 1'b1) begin
                    errors++; $display("FAIL sw_to_memwrite k=%0d got 0 want 1", k);
                end
            end
            if (k >= 7) begin
                checks++;
                if ({mem_write, mem_read, reg_write, load_pc, trap, cause}
                    !== 7'b0000_1_10) begin
                    errors++;
                    $display("FAIL sw_to_trap k=%0d got mw=%b mr=%b rw=%b lpc=%b trap=%b cause=%b",
                             k, mem_write, mem_read, reg_write, load_pc, trap, cause);
                end
            end
            step();
        end
        do_reset(); #1;
        checks++;
        if ({st, trap, cause} !== 6'd0) begin
            errors++;
            $display("FAIL sw_to_clear got st=%0d trap=%b cause=%b want 0",
                     st, trap, cause);
        end
        for (int k = 0; k < 8; k++) begin
            instr = (k == 0) ? I_SW : $urandom;
            dReady = (k == 6);
            #1;
            checks++;
            if (st !== 3'(ok_st[k])) begin
                errors++;
                $display("FAIL sw_last_ready k=%0d got %0d want %0d", k, st, ok_st[k]);
            end
            step();
        end
    endtask

    task automatic test_sra();
        logic [31:0] ins [2];
        logic [4:0]  want [2];
        ins  = '{I_SRA, I_SRAI};
        want = '{{1'b0, A_SRA}, {1'b1, A_SRA}};
        for (int j = 0; j < 2; j++) begin
            do_reset();
            instr = ins[j]; #1;
            step(); instr = $urandom;
            step(); #1;
            checks++;
            if ({st, alu_src, alu_ctrl} !== {3'd2, want[j]}) begin
                errors++;
                $display("FAIL sra_alu j=%0d got st=%0d src=%b alu=%b want %b",
                         j, st, alu_src, alu_ctrl, want[j]);
            end
            step(); #1;
            checks++;
            if ({st, reg_write, mem_to_reg} !== {3'd4, 2'b10}) begin
                errors++;
                $display("FAIL sra_wb j=%0d got st=%0d rw=%b mtr=%b",
                         j, st, reg_write, mem_to_reg);
            end
            step();
        end
    endtask

    task automatic test_rst_mid_mem();
        do_reset();
        exec_simple(I_ADD);
        instr = I_LW; dReady = 0;
        step(); instr = $urandom;
        step(); step(); step(); #1;
        checks++;
        if ({st, mem_read, rcnt} !== {3'd3, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL rst_mem_pre got st=%0d mr=%b cnt=%0d want 3/1/1",
                     st, mem_read, rcnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        checks++;
        if ({st, mem_read, rcnt} !== 8'd0) begin
            errors++;
            $display("FAIL rst_mem_post got st=%0d mr=%b cnt=%0d want 0/0/0",
                     st, mem_read, rcnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (15) exec_simple(I_ADD);
        checks++;
        if (rcnt !== 4'd15) begin
            errors++; $display("FAIL wrap_pre got %0d want 15", rcnt);
        end
        exec_simple(I_ADD);
        checks++;
        if (rcnt !== 4'd0) begin
            errors++; $display("FAIL wrap got %0d want 0", rcnt);
        end
    endtask

    task automatic test_random(input int n);
        logic [6:0]  opcs [5];
        logic [31:0] ins;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [3:0]  alu, e_alu, cnt;
        logic [1:0]  e_cause;
        logic [21:0] obs, expv;
        bit ok, e_src, e_pcs;
        int cls, dly, m, ecause, sel, p;
        int ph[$];
        opcs = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63};
        do_reset();
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            sel = $urandom_range(0, 5);
            opc = (sel == 5) ? 7'($urandom) : opcs[sel];
            f3  = 3'($urandom);
            if (sel <= 1 && $urandom_range(0, 3) != 0) f3 = 3'd2;
            sel = $urandom_range(0, 9);
            f7  = (sel < 5) ? 7'h00 : ((sel < 8) ? 7'h20 : 7'($urandom));
            ins = $urandom;
            ins[31:25] = f7; ins[14:12] = f3; ins[6:0] = opc;
            ref_dec(ins, ok, cls, alu);
            dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            ph.delete();
            ph.push_back(0); ph.push_back(1);
            ecause = 0;
            if (!ok) begin
                ecause = 1;
                repeat (3) ph.push_back(5);
            end else begin
                ph.push_back(2);
                if (cls <= 1) begin
                    if (dly != 0 && dly <= WAIT_MAX) begin
                        repeat (dly) ph.push_back(3);
                        ph.push_back(4);
                    end else begin
                        repeat (WAIT_MAX) ph.push_back(3);
                        ecause = 2;
                        repeat (2) ph.push_back(5);
                    end
                end else begin
                    ph.push_back(4);
                end
            end
            m = 0;
            foreach (ph[k]) begin
                p = ph[k];
                instr = (k == 0) ? ins : $urandom;
                Zero = 1'($urandom); Lt = 1'($urandom);
                if (p == 3) begin
                    m++;
                    dReady = (dly != 0 && m >= dly);
                end else begin
                    dReady = 1'($urandom);
                end
                #1;
                e_alu   = (p >= 1 && p <= 4) ? alu : A_AND;
                e_src   = (p >= 1 && p <= 4) && ok && (cls <= 2);
                e_pcs   = (p == 4) && (cls == 4) && ref_taken(f3, Zero, Lt);
                e_cause = (p == 5) ? 2'(ecause) : 2'b00;
                expv = {3'(p), p == 5, e_cause, e_src, e_alu,
                        p == 4 && (cls == 0 || cls == 2 || cls == 3),
                        p == 4 && cls == 0, p == 4, e_pcs,
                        p == 3 && cls == 0, p == 3 && cls == 1, p == 4, cnt};
                obs = {st, trap, cause, alu_src, alu_ctrl, reg_write,
                       mem_to_reg, load_pc, pc_src, mem_read, mem_write,
                       retired, rcnt};
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL random i=%0d ins=%h phase=%0d got %h want %h",
                             i, ins, p, obs, expv);
                end
                step();
            end
            if (ecause != 0) begin
                do_reset();
                cnt = 0;
            end else begin
                cnt = cnt + 4'd1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; instr = '0; Zero = 0; Lt = 0; dReady = 0;
        test_reset();
        test_add();
        test_lw_wait();
        test_branch(1'b0);
        test_branch(1'b1);
        test_sw_timeout();
        test_sra();
        test_rst_mid_mem();
        test_wrap();
        test_random(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
